// File: rtl/commit_trace_collector_if.sv
// Trace record stream between the commit collector and the trace/compare logic.
interface commit_trace_collector_if;
  logic        rec_valid;
  logic        rec_ready;
  logic        rec_type;
  logic [31:0] rec_pc;
  logic [31:0] rec_addr;
  logic [31:0] rec_data;
  logic [3:0]  rec_byteen;

  modport master (
    output rec_valid, rec_type, rec_pc, rec_addr, rec_data, rec_byteen,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_type, rec_pc, rec_addr, rec_data, rec_byteen,
    output rec_ready
  );
endinterface

// File: rtl/commit_trace_collector.sv
// Captures retired register writes and memory stores, normalises them and
// queues them for the trace consumer; events that find no room are counted.
module commit_trace_collector #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_grf_we,
  input  logic [4:0]               w_grf_addr,
  input  logic [31:0]              w_grf_wdata,
  input  logic [31:0]              w_inst_addr,
  input  logic [31:0]              m_data_addr,
  input  logic [31:0]              m_data_wdata,
  input  logic [3:0]               m_data_byteen,
  input  logic [31:0]              m_inst_addr,
  commit_trace_collector_if.master rec_if,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW1 = CNT_W + 1;

  typedef struct packed {
    logic        typ;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } rec_t;

  rec_t mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    level_reg, level_next;
  logic             overflow_reg, overflow_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic             g, m, acc_g, acc_m, pop;
  logic [LW-1:0]    free;
  logic [1:0]       n_acc, n_drop;
  logic [CW1-1:0]   drop_sum;
  logic [31:0]      st_data;
  rec_t             grf_rec, st_rec, head;

  // Disabled store lanes are zeroed so the consumer can compare whole words.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign st_data[gi*8 +: 8] = m_data_byteen[gi] ? m_data_wdata[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign g = w_grf_we && (w_grf_addr != 5'd0);
  assign m = (m_data_byteen != 4'd0);

  assign grf_rec = '{typ: 1'b0, pc: w_inst_addr, addr: {27'd0, w_grf_addr},
                     data: w_grf_wdata, byteen: 4'hF};
  assign st_rec  = '{typ: 1'b1, pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00},
                     data: st_data, byteen: m_data_byteen};

  // Space is judged before the same-cycle pop; the GRF event claims a slot first.
  always_comb begin
    free          = LW'(DEPTH) - level_reg;
    acc_g         = g && (free != '0);
    acc_m         = m && (free > LW'(acc_g));
    n_acc         = {1'b0, acc_g} + {1'b0, acc_m};
    n_drop        = {1'b0, g && !acc_g} + {1'b0, m && !acc_m};
    pop           = (level_reg != '0) && rec_if.rec_ready;
    wr_ptr_next   = wr_ptr_reg + AW'(n_acc);
    rd_ptr_next   = rd_ptr_reg + AW'(pop);
    level_next    = level_reg + LW'(n_acc) - LW'(pop);
    drop_sum      = {1'b0, drop_cnt_reg} + CW1'(n_drop);
    drop_cnt_next = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    overflow_next = overflow_reg || (n_drop != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (acc_g) mem[wr_ptr_reg] <= grf_rec;
      if (acc_m) mem[wr_ptr_reg + AW'(acc_g)] <= st_rec;
    end
  end

  assign head              = mem[rd_ptr_reg];
  assign rec_if.rec_valid  = (level_reg != '0);
  assign rec_if.rec_type   = head.typ;
  assign rec_if.rec_pc     = head.pc;
  assign rec_if.rec_addr   = head.addr;
  assign rec_if.rec_data   = head.data;
  assign rec_if.rec_byteen = head.byteen;

  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;
  assign level    = level_reg;

endmodule

// File: doc/commit_trace_collector.md
Name: commit_trace_collector

Overview:
- Downstream consumer of the core's retirement and store ports: w_grf_*, w_inst_addr, m_data_*, m_inst_addr.
- Each cycle it captures at most one register-write event and one memory-store event, normalises them, and queues them in a FIFO.
- Records drain in program-visible order over a valid/ready stream to the trace/compare logic.
- Overflow is detected and counted, never silently hidden.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- CNT_W, 16, width of the dropped-event counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- w_grf_we  in  1  register-file write enable from W stage.
- w_grf_addr  in  5  destination register.
- w_grf_wdata  in  32  register write data.
- w_inst_addr  in  32  PC of the writing instruction.
- m_data_addr  in  32  byte address from M stage.
- m_data_wdata  in  32  store data, lane-aligned.
- m_data_byteen  in  4  byte enables; nonzero means a store.
- m_inst_addr  in  32  PC of the storing instruction.
- rec_valid  out  1  head record available.
- rec_ready  in  1  consumer accepts head record.
- rec_type  out  1  0 = GRF write, 1 = memory store.
- rec_pc  out  32  instruction address of the record.
- rec_addr  out  32  GRF: {27'b0, reg}; store: word-aligned address.
- rec_data  out  32  GRF: wdata; store: wdata with disabled bytes forced to 0.
- rec_byteen  out  4  GRF: 4'b1111; store: m_data_byteen.
- overflow  out  1  sticky, set on the first dropped event.
- drop_cnt  out  CNT_W  saturating count of dropped events.
- level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (sampled at posedge clk): rd_ptr = wr_ptr = 0, level = 0, rec_valid = 0, overflow = 0, drop_cnt = 0. Inputs in the reset cycle are ignored. Reset mid-stream discards all queued records. rec_type/pc/addr/data/byteen are don't-care while rec_valid = 0; the bench checks them only when valid.
- Event qualification at each posedge, when not in reset:
  - g = w_grf_we && (w_grf_addr != 0). Writes to $0 never produce a record.
  - m = (m_data_byteen != 0).
- Store normalisation:
  - aligned address = m_data_addr & 32'hFFFF_FFFC.
  - data byte k is kept iff byteen[k], otherwise 0.
- Ordering: when g and m occur in the same cycle, the GRF record is written first (slot wr_ptr) and the store second (wr_ptr+1).
- Pop: when rec_valid && rec_ready at a posedge, rd_ptr increments modulo DEPTH.
- Space: free = DEPTH - level, taken before the same-cycle pop. A pop does not free space for a push in the same cycle.
- Accept/drop:
  - n_req = g + m.
  - If n_req <= free, accept all.
  - Otherwise accept in order (GRF first) up to free and drop the rest.
  - Each dropped event adds 1 to drop_cnt, saturating at all-ones; overflow is set to 1.
- Level update: level_next = level + accepted − popped.
- Pointers wrap modulo DEPTH. Level reaches exactly DEPTH at full.
- Output timing:
  - rec_valid = (level != 0).
  - rec_* reflect storage[rd_ptr] combinationally from registered state.
  - An event sampled at edge N is visible on the outputs after edge N: one-cycle latency into an empty FIFO.
- Handshake: rec_* are held stable while rec_valid && !rec_ready.

Test Plan:
- GRF write: w_grf_we=1, addr=5, wdata=0x12345678, w_inst_addr=0x3000, one cycle, ready=1 -> next cycle rec_valid=1, type=0, pc=0x3000, addr=0x5, data=0x12345678, byteen=1111; level returns to 0 after the pop.
- $0 write: w_grf_we=1, addr=0 -> no record; rec_valid stays 0.
- Byte store: m_data_addr=0x1003, byteen=1000, wdata=0xAABBCCDD, m_inst_addr=0x3010 -> type=1, addr=0x1000, data=0xAA000000, byteen=1000.
- Dual event: GRF $3 and store at 0x4 (byteen=1111) in the same cycle, ready=1 -> GRF record first, store record the next cycle.
- Overflow: ready=0, 16 single GRF writes (level=16), then one dual event -> both dropped, overflow=1, drop_cnt=2, level=16. Then ready=1 with one GRF event at full -> pop occurs, event dropped, drop_cnt=3, level=15.
- Reset mid-stream: level=7, assert reset for 1 cycle with both events present -> level=0, rec_valid=0, drop_cnt=0, overflow=0, no records enqueued.
